mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 30 +++
 rtl/mem_store_array.sv | 40 ++++
 rtl/mem_responder.sv | 187 ++++++++++++++++++
 tb/tb_mem_responder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared memory constants and the responder state encoding.
// The MEM_DATA_* macros are also used by the cache, so they are guarded so
// that whichever file defines them first provides the value.
//
// Contents:
//   `MEM_DATA_BITS   - width of one memory chunk / beat (128)
//   `MEM_DATA_CYCLES - beats per 512-bit line (4)
//   mem_state_e      - responder FSM state encoding
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif
`ifndef MEM_DATA_CYCLES
`define MEM_DATA_CYCLES 4
`endif

package mem_responder_pkg;

  localparam int MemDataBits   = `MEM_DATA_BITS;
  localparam int MemDataCycles = `MEM_DATA_CYCLES;
  localparam int MemMaskBits   = MemDataBits / 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_WAIT   = 3'd1,
    RD_BURST  = 3'd2,
    NACK      = 3'd3,
    WR_COMMIT = 3'd4
  } mem_state_e;

endpackage

// File: rtl/mem_store_array.sv
// Backing store: 2**STORE_LG2 chunks of `MEM_DATA_BITS, single port,
// byte-masked synchronous write, combinational read of the same address.
//
// Ports:
//   clk     - clock
//   we_i    - write enable (writes on the rising edge)
//   addr_i  - chunk index, shared by read and write
//   wdata_i - write data
//   mask_i  - byte enables, bit b covers wdata_i[8*b +: 8]
//   rdata_o - combinational read data at addr_i
module mem_store_array
  import mem_responder_pkg::*;
#(
  parameter int STORE_LG2 = 10
) (
  input  logic                          clk,
  input  logic                          we_i,
  input  logic [STORE_LG2-1:0]          addr_i,
  input  logic [`MEM_DATA_BITS-1:0]     wdata_i,
  input  logic [`MEM_DATA_BITS/8-1:0]   mask_i,
  output logic [`MEM_DATA_BITS-1:0]     rdata_o
);

  logic [`MEM_DATA_BITS-1:0] mem_q [2**STORE_LG2];

  // NOTE: the array has no reset; clearing it would turn it into a huge
  // flop bank instead of a RAM, and its contents are undefined at power-up.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < `MEM_DATA_BITS/8; b++) begin
        if (mask_i[b]) begin
          mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts 128-bit chunk write requests and 512-bit line
// read requests, answering reads with four ascending beats after a fixed
// latency, or with a one-cycle nack on every NACK_EVERY-th read.
//
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   mem_req_val/rdy      - request handshake (rdy only in IDLE)
//   mem_req_addr/rw      - chunk address, 1 = write
//   mem_req_data_*       - write data, byte mask, chunk offset in line,
//                          valid qualifier and one-cycle commit pulse
//   mem_resp_val/nack    - read beat valid / read refused
//   mem_resp_data        - read beat data, zero when mem_resp_val is low
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_BITS  = 26,
  parameter int STORE_LG2  = 10,
  parameter int LATENCY    = 2,
  parameter int NACK_EVERY = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mem_req_val,
  output logic                        mem_req_rdy,
  input  logic [ADDR_BITS-1:0]        mem_req_addr,
  input  logic                        mem_req_rw,
  input  logic                        mem_req_data_valid,
  output logic                        mem_req_data_ready,
  input  logic [`MEM_DATA_BITS-1:0]   mem_req_data_bits,
  input  logic [`MEM_DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic [1:0]                  mem_req_data_offset,
  output logic                        mem_resp_val,
  output logic                        mem_resp_nack,
  output logic [`MEM_DATA_BITS-1:0]   mem_resp_data
);

  localparam int LineBits = STORE_LG2 - 2;
  localparam int CntW     = 16;
  localparam logic [1:0] LastBeat = 2'(`MEM_DATA_CYCLES - 1);
  // The read counter runs modulo NACK_EVERY so "count mod N == 0" is simply
  // "counter wrapped to zero" and never suffers from counter overflow.
  localparam logic [CntW-1:0] NackWrap =
    (NACK_EVERY > 0) ? CntW'(NACK_EVERY - 1) : '0;

  function automatic logic nack_due(input logic [CntW-1:0] cnt);
    return (NACK_EVERY != 0) && (cnt == '0);
  endfunction

  mem_state_e                  state_q, state_d;
  logic [LineBits-1:0]         line_q, line_d;
  logic [1:0]                  off_q, off_d;
  logic [`MEM_DATA_BITS-1:0]   wdata_q, wdata_d;
  logic [`MEM_DATA_BITS/8-1:0] mask_q, mask_d;
  logic [1:0]                  beat_q, beat_d;
  logic [3:0]                  lat_q, lat_d;
  logic [CntW-1:0]             rd_cnt_q, rd_cnt_d;

  logic                        accept;
  logic                        store_we;
  logic [STORE_LG2-1:0]        store_addr;
  logic [`MEM_DATA_BITS-1:0]   store_rdata;

  // Address bits above the store and the in-line chunk bits alias freely.
  logic unused_addr;
  assign unused_addr = ^{mem_req_addr[ADDR_BITS-1:STORE_LG2], mem_req_addr[1:0]};

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d            = state_q;
    line_d             = line_q;
    off_d              = off_q;
    wdata_d            = wdata_q;
    mask_d             = mask_q;
    beat_d             = beat_q;
    lat_d              = lat_q;
    rd_cnt_d           = rd_cnt_q;
    accept             = 1'b0;
    store_we           = 1'b0;
    store_addr         = {line_q, beat_q};
    mem_req_rdy        = 1'b0;
    mem_req_data_ready = 1'b0;
    mem_resp_val       = 1'b0;
    mem_resp_nack      = 1'b0;
    mem_resp_data      = '0;

    case (state_q)
      IDLE: begin
        // A write without its data is refused outright rather than parked.
        mem_req_rdy = !reset && !(mem_req_val && mem_req_rw && !mem_req_data_valid);
        accept      = mem_req_val && mem_req_rdy;
        if (accept) begin
          line_d = mem_req_addr[STORE_LG2-1:2];
          if (mem_req_rw) begin
            off_d   = mem_req_data_offset;
            wdata_d = mem_req_data_bits;
            mask_d  = mem_req_data_mask;
            state_d = WR_COMMIT;
          end else begin
            beat_d   = 2'd0;
            rd_cnt_d = (NACK_EVERY != 0 && rd_cnt_q == NackWrap) ? '0 : rd_cnt_q + 1'b1;
            if (LATENCY == 1) begin
              // No wait cycles at all: answer on the very next cycle.
              state_d = nack_due(rd_cnt_d) ? NACK : RD_BURST;
            end else begin
              lat_d   = 4'(LATENCY - 1);
              state_d = RD_WAIT;
            end
          end
        end
      end
      RD_WAIT: begin
        // Leave when the decremented count reaches zero, so the first beat
        // lands exactly LATENCY cycles after accept.
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) begin
          state_d = nack_due(rd_cnt_q) ? NACK : RD_BURST;
        end
      end
      RD_BURST: begin
        mem_resp_val  = 1'b1;
        mem_resp_data = store_rdata;
        beat_d        = beat_q + 2'd1;
        if (beat_q == LastBeat) begin
          state_d = IDLE;
        end
      end
      NACK: begin
        mem_resp_nack = 1'b1;
        state_d       = IDLE;
      end
      WR_COMMIT: begin
        store_we           = 1'b1;
        store_addr         = {line_q, off_q};
        mem_req_data_ready = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset wins over any in-flight transfer: no write, no beat, no nack.
    if (reset) begin
      store_we           = 1'b0;
      mem_req_data_ready = 1'b0;
      mem_resp_val       = 1'b0;
      mem_resp_nack      = 1'b0;
      mem_resp_data      = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      beat_q   <= 2'd0;
      lat_q    <= 4'd0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      lat_q    <= lat_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Capture registers are only meaningful after an accept, so they carry
  // no reset.
  always_ff @(posedge clk) begin
    line_q  <= line_d;
    off_q   <= off_d;
    wdata_q <= wdata_d;
    mask_q  <= mask_d;
  end

  mem_store_array #(
    .STORE_LG2 (STORE_LG2)
  ) u_store (
    .clk     (clk),
    .we_i    (store_we),
    .addr_i  (store_addr),
    .wdata_i (wdata_q),
    .mask_i  (mask_q),
    .rdata_o (store_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder (LATENCY=2, NACK_EVERY=2).
// A byte-level model of the store predicts read beats; expected beats are
// queued when a read is issued and popped as the DUT returns them.
module tb_mem_responder;

  localparam int DW  = 128;
  localparam int MW  = DW / 8;
  localparam int AW  = 26;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_req_val;
  logic          mem_req_rdy;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_rw;
  logic          mem_req_data_valid;
  logic          mem_req_data_ready;
  logic [DW-1:0] mem_req_data_bits;
  logic [MW-1:0] mem_req_data_mask;
  logic [1:0]    mem_req_data_offset;
  logic          mem_resp_val;
  logic          mem_resp_nack;
  logic [DW-1:0] mem_resp_data;

  int checks = 0;
  int errors = 0;
  int rd_n   = 0;

  logic [DW-1:0] model_mem [1024];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] beat0;

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_BITS  (AW),
    .STORE_LG2  (10),
    .LATENCY    (LAT),
    .NACK_EVERY (2)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .mem_req_val         (mem_req_val),
    .mem_req_rdy         (mem_req_rdy),
    .mem_req_addr        (mem_req_addr),
    .mem_req_rw          (mem_req_rw),
    .mem_req_data_valid  (mem_req_data_valid),
    .mem_req_data_ready  (mem_req_data_ready),
    .mem_req_data_bits   (mem_req_data_bits),
    .mem_req_data_mask   (mem_req_data_mask),
    .mem_req_data_offset (mem_req_data_offset),
    .mem_resp_val        (mem_resp_val),
    .mem_resp_nack       (mem_resp_nack),
    .mem_resp_data       (mem_resp_data)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {rdy, val, nack, data_ready}
  function automatic logic [3:0] ctl();
    return {mem_req_rdy, mem_resp_val, mem_resp_nack, mem_req_data_ready};
  endfunction

  task automatic wait_rdy(input string tag);
    bit got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mem_req_rdy === 1'b1) begin
        got = 1;
        break;
      end
    end
    check(tag, DW'(got), DW'(1));
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after WR_COMMIT.
  task automatic do_write(input logic [AW-1:0] addr, input logic [1:0] off,
                          input logic [DW-1:0] data, input logic [MW-1:0] mask);
    logic [9:0] idx;
    mem_req_val         = 1'b1;
    mem_req_rw          = 1'b1;
    mem_req_data_valid  = 1'b1;
    mem_req_addr        = addr;
    mem_req_data_offset = off;
    mem_req_data_bits   = data;
    mem_req_data_mask   = mask;
    wait_rdy("wr_accept");
    @(posedge clk);
    #1;
    mem_req_val        = 1'b0;
    mem_req_data_valid = 1'b0;
    idx = {addr[9:2], off};
    for (int b = 0; b < MW; b++)
      if (mask[b]) model_mem[idx][b*8 +: 8] = data[b*8 +: 8];
    @(negedge clk);
    check("wr_commit_pulse", DW'(mem_req_data_ready), DW'(1));
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the response ends.
  task automatic do_read(input logic [AW-1:0] addr, output logic [DW-1:0] first);
    bit exp_nack;
    int lat = 0;
    first = '0;
    rd_n++;
    exp_nack = (rd_n % 2 == 0);
    if (!exp_nack)
      for (int k = 0; k < 4; k++) exp_q.push_back(model_mem[{addr[9:2], 2'(k)}]);
    mem_req_val  = 1'b1;
    mem_req_rw   = 1'b0;
    mem_req_addr = addr;
    wait_rdy("rd_accept");
    check("rd_accept_no_ready", DW'(mem_req_data_ready), DW'(0));
    @(posedge clk);
    #1;
    mem_req_val = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (mem_resp_val === 1'b1 || mem_resp_nack === 1'b1) begin
        lat = n;
        break;
      end
      check("rd_wait_quiet", DW'(ctl()), DW'(4'b0000));
    end
    check("rd_latency", DW'(lat), DW'(LAT));
    check("rd_nack_kind", DW'(mem_resp_nack), DW'(exp_nack));
    if (exp_nack) begin
      check("nack_no_val", DW'({mem_resp_val, mem_req_rdy}), DW'(0));
      @(negedge clk);
      check("nack_done", DW'(ctl()), DW'(4'b1000));
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (k > 0) @(negedge clk);
        check($sformatf("beat%0d_ctl", k), DW'(ctl()), DW'(4'b0100));
        if (exp_q.size() != 0) begin
          if (k == 0) first = mem_resp_data;
          check($sformatf("beat%0d_data", k), mem_resp_data, exp_q.pop_front());
        end else begin
          check("scoreboard_empty", DW'(1), DW'(0));
        end
      end
      @(negedge clk);
      check("burst_done_ctl", DW'(ctl()), DW'(4'b1000));
      check("burst_done_data", mem_resp_data, '0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset               = 1'b1;
    mem_req_val         = 1'b0;
    mem_req_rw          = 1'b0;
    mem_req_addr        = '0;
    mem_req_data_valid  = 1'b0;
    mem_req_data_bits   = '0;
    mem_req_data_mask   = '0;
    mem_req_data_offset = 2'd0;

    // Reset held: rdy low, all responses low.
    repeat (3) begin
      @(negedge clk);
      check("in_reset_ctl", DW'(ctl()), DW'(4'b0000));
      check("in_reset_data", mem_resp_data, '0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle for 10 cycles after reset.
    repeat (10) begin
      @(negedge clk);
      check("idle_ctl", DW'(ctl()), DW'(4'b1000));
      check("idle_data", mem_resp_data, '0);
    end
    @(posedge clk);
    #1;

    // Fill line 0x10, then the 0xA5 chunk, then read (read-after-write).
    do_write(26'h10, 2'd1, {4{32'h1111_0001}}, 16'hFFFF);
    do_write(26'h10, 2'd2, {4{32'h2222_0002}}, 16'hFFFF);
    do_write(26'h10, 2'd3, {4{32'h3333_0003}}, 16'hFFFF);
    do_write(26'h10, 2'd0, {16{8'hA5}}, 16'hFFFF);
    do_read(26'h10, beat0);                        // read 1: beats
    check("a5_beat0", beat0, {16{8'hA5}});

    // Partial byte merge into an all-ones chunk; the first read of it is
    // the second read overall and is nacked, the re-issue returns data.
    do_write(26'h20, 2'd1, {4{32'h4444_0004}}, 16'hFFFF);
    do_write(26'h20, 2'd2, {4{32'h5555_0005}}, 16'hFFFF);
    do_write(26'h20, 2'd3, {4{32'h6666_0006}}, 16'hFFFF);
    do_write(26'h20, 2'd0, {DW{1'b1}}, 16'hFFFF);
    do_write(26'h20, 2'd0, 128'h0000_0000_0000_0000_0000_0000_1122_3344, 16'h000F);
    do_read(26'h20, beat0);                        // read 2: nack
    do_read(26'h20, beat0);                        // read 3: beats
    check("merge_beat0", beat0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_1122_3344);

    // All-zero mask: store unchanged, commit still pulses.
    do_write(26'h10, 2'd1, {DW{1'b0}}, 16'h0000);
    do_read(26'h10, beat0);                        // read 4: nack

    // Reset during beat 2 of a burst (read 5).
    rd_n++;
    mem_req_val  = 1'b1;
    mem_req_rw   = 1'b0;
    mem_req_addr = 26'h10;
    wait_rdy("rst_rd_accept");
    @(posedge clk);
    #1;
    mem_req_val = 1'b0;
    repeat (3) @(negedge clk);                     // RD_WAIT, beat 0, beat 1
    check("rst_beat1_val", DW'(mem_resp_val), DW'(1));
    check("rst_beat1_data", mem_resp_data, model_mem[10'h11]);
    @(posedge clk);
    #1;
    reset = 1'b1;                                  // beat 2 cycle
    @(negedge clk);
    check("rst_beat2_ctl", DW'(ctl()), DW'(4'b0000));
    check("rst_beat2_data", mem_resp_data, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd_n  = 0;
    exp_q.delete();
    @(negedge clk);
    check("rst_release_rdy", DW'(ctl()), DW'(4'b1000));
    repeat (5) begin
      @(negedge clk);
      check("rst_abort_quiet", DW'(ctl()), DW'(4'b1000));
    end
    @(posedge clk);
    #1;

    // Write without data_valid is held off and does not touch the store.
    mem_req_val         = 1'b1;
    mem_req_rw          = 1'b1;
    mem_req_data_valid  = 1'b0;
    mem_req_addr        = 26'h10;
    mem_req_data_offset = 2'd2;
    mem_req_data_bits   = {16{8'h5A}};
    mem_req_data_mask   = 16'hFFFF;
    repeat (5) begin
      @(negedge clk);
      check("nodv_rdy", DW'({mem_req_rdy, mem_req_data_ready}), DW'(0));
      @(posedge clk);
      #1;
    end
    mem_req_val = 1'b0;
    do_read(26'h10, beat0);                        // read 1 after reset: beats

    // Same stall, then data_valid rises and is accepted that cycle.
    mem_req_val = 1'b1;
    mem_req_rw  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("nodv2_rdy", DW'(mem_req_rdy), DW'(0));
      @(posedge clk);
      #1;
    end
    mem_req_data_valid = 1'b1;
    @(negedge clk);
    check("dv_rdy_same_cycle", DW'(mem_req_rdy), DW'(1));
    @(posedge clk);
    #1;
    mem_req_val        = 1'b0;
    mem_req_data_valid = 1'b0;
    model_mem[10'h12]  = {16{8'h5A}};
    @(negedge clk);
    check("dv_commit_pulse", DW'(mem_req_data_ready), DW'(1));
    @(posedge clk);
    #1;

    // Aliased address (bit 10 set) reaches the same line.
    do_read(26'h410, beat0);                       // read 2: nack
    do_read(26'h410, beat0);                       // read 3: beats, chunk 0x12 = 5A
    check("alias_beat0", beat0, {16{8'hA5}});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
